// File: rtl/instr_encoder_pkg.sv
// Shared constants for the RISC-V encode path: format codes, error codes,
// FIFO entry layout and an immediate range helper.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    NO = 3'd0,
    RT = 3'd1,
    IT = 3'd2,
    ST = 3'd3,
    BT = 3'd4,
    UT = 3'd5,
    JT = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_OP    = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_ALIGN = 2'd3
  } err_e;

  typedef struct packed {
    logic [31:0] instr;
    err_e        err;
  } fifo_ent_t;

  localparam int FIFO_DEPTH = 2;

  // Immediates arrive as full signed byte values; compare as two's complement.
  function automatic logic imm_in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-in / word-out handshake bundle of the instruction encoder.
interface instr_encoder_if;
  logic        i_valid;
  logic        o_ready;
  logic [6:0]  i_op;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [31:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [1:0]  o_err;

  modport slave (
    input  i_valid, i_op, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_ready,
    output o_ready, o_valid, o_instr, o_err
  );

  modport master (
    output i_valid, i_op, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_ready,
    input  o_ready, o_valid, o_instr, o_err
  );
endinterface

// File: rtl/instr_encoder_dec.sv
// Opcode to instruction-format lookup, shared with the decode path.
module instr_encoder_dec
  import instr_encoder_pkg::*;
(
  input  logic [6:0] i_op,
  output fmt_e       o_fmt
);

  always_comb begin
    o_fmt = NO;
    casez (i_op)
      7'b0?1_0111: o_fmt = UT;  // lui / auipc
      7'b110_1111: o_fmt = JT;
      7'b110_0011: o_fmt = BT;
      7'b010_0011: o_fmt = ST;
      7'b001_0011,
      7'b000_0011,
      7'b110_0111,
      7'b111_0011: o_fmt = IT;
      7'b011_0011: o_fmt = RT;
      default:     o_fmt = NO;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded fields into a 32-bit RISC-V word with immediate checks,
// buffering results in a 2-entry FIFO and counting delivered good/bad words.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] o_cnt_ok,
  output logic [CNT_W-1:0] o_cnt_err
);

  fmt_e        fmt;
  logic [31:0] word;
  logic [31:0] enc_instr;
  err_e        enc_err;

  instr_encoder_dec u_dec (
    .i_op  (bus.i_op),
    .o_fmt (fmt)
  );

  // Alignment outranks range, so odd out-of-range offsets report misaligned.
  always_comb begin
    word    = '0;
    enc_err = ERR_OK;
    case (fmt)
      RT: word = {bus.i_funct7, bus.i_rs2, bus.i_rs1, bus.i_funct3, bus.i_rd, bus.i_op};
      IT: begin
        word = {bus.i_imm[11:0], bus.i_rs1, bus.i_funct3, bus.i_rd, bus.i_op};
        if (!imm_in_range(bus.i_imm, -2048, 2047)) enc_err = ERR_RANGE;
      end
      ST: begin
        word = {bus.i_imm[11:5], bus.i_rs2, bus.i_rs1, bus.i_funct3, bus.i_imm[4:0], bus.i_op};
        if (!imm_in_range(bus.i_imm, -2048, 2047)) enc_err = ERR_RANGE;
      end
      BT: begin
        word = {bus.i_imm[12], bus.i_imm[10:5], bus.i_rs2, bus.i_rs1, bus.i_funct3,
                bus.i_imm[4:1], bus.i_imm[11], bus.i_op};
        if (bus.i_imm[0])                               enc_err = ERR_ALIGN;
        else if (!imm_in_range(bus.i_imm, -4096, 4094)) enc_err = ERR_RANGE;
      end
      UT: begin
        word = {bus.i_imm[31:12], bus.i_rd, bus.i_op};
        if (bus.i_imm[11:0] != 12'h0) enc_err = ERR_ALIGN;
      end
      JT: begin
        word = {bus.i_imm[20], bus.i_imm[10:1], bus.i_imm[11], bus.i_imm[19:12],
                bus.i_rd, bus.i_op};
        if (bus.i_imm[0])                                     enc_err = ERR_ALIGN;
        else if (!imm_in_range(bus.i_imm, -1048576, 1048574)) enc_err = ERR_RANGE;
      end
      default: enc_err = ERR_OP;
    endcase
    enc_instr = (enc_err == ERR_OK) ? word : 32'h0;
  end

  fifo_ent_t        mem_q [FIFO_DEPTH];
  fifo_ent_t        mem_d [FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;
  fifo_ent_t        head;
  logic             do_wr, do_rd;

  // Ready depends only on occupancy, so a full FIFO stalls even when draining.
  assign bus.o_ready = (cnt_q != 2'd2);
  assign bus.o_valid = (cnt_q != 2'd0);
  assign head        = mem_q[rd_ptr_q];
  assign bus.o_instr = head.instr;
  assign bus.o_err   = head.err;
  assign o_cnt_ok    = cnt_ok_q;
  assign o_cnt_err   = cnt_err_q;

  assign do_wr = bus.i_valid && bus.o_ready;
  assign do_rd = bus.o_valid && bus.i_ready;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    cnt_ok_d  = cnt_ok_q;
    cnt_err_d = cnt_err_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = '{instr: enc_instr, err: enc_err};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_rd) begin
      rd_ptr_d = ~rd_ptr_q;
      if (head.err == ERR_OK) begin
        if (cnt_ok_q != '1) cnt_ok_d = cnt_ok_q + CNT_W'(1);
      end else begin
        if (cnt_err_q != '1) cnt_err_d = cnt_err_q + CNT_W'(1);
      end
    end
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      cnt_ok_q  <= cnt_ok_d;
      cnt_err_q <= cnt_err_d;
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RISC-V instruction encoder: accepts decoded instruction fields (opcode, registers, funct, 32-bit immediate) over a valid/ready handshake and packs them into a 32-bit instruction word. Format is derived from the opcode, and the immediate is range- and alignment-checked per format. Results go through a 2-entry output FIFO with its own valid/ready handshake. Sits on the encode path feeding instruction-memory loaders and self-test generators, the inverse of the opcode→format decode path.

## Interface
Parameters:
- CNT_W, 16, width of the saturating OK/error counters

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  input fields valid
- o_ready  out  1  encoder can accept fields this cycle
- i_op  in  7  opcode
- i_rd, i_rs1, i_rs2  in  5 each  register indices
- i_funct3  in  3  funct3
- i_funct7  in  7  funct7 (R-type only)
- i_imm  in  32  immediate, full signed byte value (U: full 32-bit value)
- o_valid  out  1  output word valid
- i_ready  in  1  consumer accepts output
- o_instr  out  32  encoded instruction
- o_err  out  2  0 ok, 1 unsupported opcode, 2 immediate out of range, 3 immediate misaligned
- o_cnt_ok, o_cnt_err  out  CNT_W  saturating counts of delivered good / error words

## Operation
- Format from opcode via shared format codes: RT, IT, ST, BT, UT, JT, NO (NO = unsupported, includes 7'b0?1_0111 → UT, 110_1111 → JT, 110_0011 → BT, 010_0011 → ST, 001_0011/000_0011/110_0111/111_0011 → IT, 011_0011 → RT).
- Packing:
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Unused fields ignored. I-type shift encodings are the caller's responsibility.
- Checks:
  - I/S: −2048..2047
  - B: −4096..4094, bit0=0
  - J: −2^20..2^20−2, bit0=0
  - U: imm[11:0]=0, flagged as misaligned
  - R: imm ignored
- Error priority: opcode (1) > misaligned (3) > range (2).
- Error words are still delivered, with o_instr=32'h0 and o_err≠0.
- FIFO: 2 entries, each holding {instr, err}.
  - o_ready = (count<2), a function of state only.
  - Write on i_valid&&o_ready; read on o_valid&&i_ready.
  - Simultaneous read/write: count unchanged. When full, only a read is possible.
  - Order strictly preserved. Head entry stable while o_valid&&!i_ready.
- Counters increment on each output handshake (o_cnt_ok if err=0, else o_cnt_err) and saturate at all-ones.

## Timing
- Latency: accepted in cycle N → o_valid at N+1 when FIFO was empty. Throughput 1 word/cycle with i_ready held high.
- Encoding and checks combinational on inputs; storage registered; o_instr/o_err driven from head entry (no combinational input→output path).
- o_ready has no combinational dependence on i_ready. A full FIFO stalls one cycle even if read this cycle.
- Reset outputs: o_valid=0, o_ready=1 (next cycle after reset deasserts), o_instr=0, o_err=0, counters=0, pointers/count=0.
- Reset mid-operation: all FIFO contents discarded, counters cleared. No handshake honoured in the reset cycle.
- Pointer wrap: 1-bit pointers toggle; count 0..2.

## Structure
- Shared format constants (RT, IT, ST, BT, UT, JT, NO = 3'd1..6, 3'd0 respectively) and error codes (ERR_OK, ERR_OP, ERR_RANGE, ERR_ALIGN) in the shared IType constants include.
- One sub-module: the existing InstrDecoder instance for opcode→format. Packing, checks, FIFO and counters are in instr_encoder.

## Test plan
- Format sweep, no backpressure, checking each o_instr value and o_err=0:
  - addi x1,x0,5 → 0x00500093
  - add x3,x1,x2 → 0x002081B3
  - sw x2,8(x1) → 0x0020A423
  - beq x1,x2,+16 → 0x00208863
  - jal x1,+2048 → 0x001000EF
  - lui x5,0x12345000 → 0x123452B7
- Errors:
  - op 7'h7F → err 1, instr 0
  - addi imm 2048 → err 2
  - beq imm 3 → err 3
  - lui imm 0x12345001 → err 3
  - op 7'h7F with imm 3 → err 1 (priority)
- Backpressure: i_ready=0, three back-to-back inputs → two accepted, o_ready=0 on third. Release i_ready → words out in order, head stable while stalled.
- Simultaneous read/write at count 1 with continuous stream → 1 word/cycle, no loss or duplication.
- Counters: CNT_W=2, deliver 5 good + 1 bad → o_cnt_ok=3 (saturated), o_cnt_err=1.
- Reset with FIFO full → next cycle o_valid=0, o_ready=1, counters 0. Subsequent addi encodes correctly.
